// File: rtl/mac_arbiter.sv
// Two-requester round-robin front end for a shared multiply-accumulate unit.
// Define MAC_ARB_TIMEOUT_EN to build the WAIT-state watchdog.
module mac_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [3:0]  a0,
  input  logic [3:0]  b0,
  output logic        gnt0,
  input  logic        req1,
  input  logic [3:0]  a1,
  input  logic [3:0]  b1,
  output logic        gnt1,
  output logic        mac_go,
  output logic [3:0]  mac_a,
  output logic [3:0]  mac_b,
  input  logic        mac_done,
  input  logic [11:0] mac_out,
  output logic        res_valid,
  output logic        res_id,
  output logic [11:0] res_data,
  output logic        res_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        prio_q, prio_d;
  logic [3:0]  a_q, a_d;
  logic [3:0]  b_q, b_d;
  logic [11:0] data_q, data_d;
  logic        winner;
  logic        expire;

`ifdef MAC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // Fires at the end of the TIMEOUT_CYCLES-th WAIT cycle.
  assign expire = (state_q == WAIT) &&
                  (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == ISSUE) begin
      cnt_d = '0;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q + CW'(1);
      if (mac_done) err_d = 1'b0;
      else if (expire) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign res_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign expire  = 1'b0;
  assign res_err = 1'b0;
`endif

  // prio_q names the requester that wins a tie.
  assign winner = (req0 & req1) ? prio_q : req1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req0 | req1) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (mac_done | expire) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d = owner_q;
    prio_d  = prio_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          owner_d = winner;
          a_d     = winner ? a1 : a0;
          b_d     = winner ? b1 : b0;
        end
      end
      WAIT: begin
        if (mac_done) data_d = mac_out;
        else if (expire) data_d = '0;
      end
      RESP:    prio_d = ~owner_q;
      default: ;
    endcase
  end

  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    mac_go    = 1'b0;
    res_valid = 1'b0;
    busy      = (state_q != IDLE);
    if (state_q == ISSUE) begin
      gnt0   = ~owner_q;
      gnt1   = owner_q;
      mac_go = 1'b1;
    end
    if (state_q == RESP) res_valid = 1'b1;
  end

  assign mac_a    = a_q;
  assign mac_b    = b_q;
  assign res_id   = owner_q;
  assign res_data = data_q;

endmodule

// File: tb/tb_mac_arbiter.sv
// Directed bench for mac_arbiter: single job, tie/fairness,
// reset abort, spurious done, and the optional watchdog.
module tb_mac_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [3:0]  a0, b0, a1, b1;
  logic        gnt0, gnt1, mac_go;
  logic [3:0]  mac_a, mac_b;
  logic        mac_done;
  logic [11:0] mac_out;
  logic        res_valid, res_id, res_err, busy;
  logic [11:0] res_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mac_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .gnt0(gnt0),
    .req1(req1), .a1(a1), .b1(b1), .gnt1(gnt1),
    .mac_go(mac_go), .mac_a(mac_a), .mac_b(mac_b),
    .mac_done(mac_done), .mac_out(mac_out),
    .res_valid(res_valid), .res_id(res_id),
    .res_data(res_data), .res_err(res_err), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [11:0] obs,
                     input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt0"}, gnt0, 0);
    chk({tag, "_gnt1"}, gnt1, 0);
    chk({tag, "_go"}, mac_go, 0);
    chk({tag, "_mac_a"}, mac_a, 0);
    chk({tag, "_mac_b"}, mac_b, 0);
    chk({tag, "_valid"}, res_valid, 0);
    chk({tag, "_id"}, res_id, 0);
    chk({tag, "_data"}, res_data, 0);
    chk({tag, "_err"}, res_err, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req0 = 0; req1 = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    mac_done = 0; mac_out = 0;
    do_reset();
    chk_zero("reset");

    // Single job from requester 0, done after 4 WAIT cycles.
    req0 = 1; a0 = 4'd3; b0 = 4'd5;
    tick();
    chk("single_gnt0", gnt0, 1);
    chk("single_gnt1", gnt1, 0);
    chk("single_go", mac_go, 1);
    chk("single_mac_a", mac_a, 3);
    chk("single_mac_b", mac_b, 5);
    chk("single_busy", busy, 1);
    req0 = 0; a0 = 4'd9; b0 = 4'd9;
    tick();
    chk("single_gnt0_pulse", gnt0, 0);
    chk("single_go_pulse", mac_go, 0);
    chk("single_a_stable", mac_a, 3);
    tick();
    tick();
    tick();
    chk("single_no_early_valid", res_valid, 0);
    mac_done = 1; mac_out = 12'd15;
    tick();
    mac_done = 0; mac_out = 0;
    chk("single_valid", res_valid, 1);
    chk("single_id", res_id, 0);
    chk("single_data", res_data, 15);
    chk("single_err", res_err, 0);
    tick();
    chk("single_valid_pulse", res_valid, 0);
    chk("single_idle_busy", busy, 0);
    chk("single_data_hold", res_data, 15);

    // Spurious done while idle.
    mac_done = 1; mac_out = 12'hFFF;
    tick();
    mac_done = 0; mac_out = 0;
    chk("spur_valid", res_valid, 0);
    chk("spur_data", res_data, 15);
    chk("spur_busy", busy, 0);
    tick();
    chk("spur_valid2", res_valid, 0);

    // Tie right after reset, then fairness over 6 jobs.
    do_reset();
    req0 = 1; req1 = 1;
    a0 = 4'd1; b0 = 4'd2; a1 = 4'd3; b1 = 4'd4;
    for (int j = 0; j < 6; j++) begin
      tick();
      chk("fair_gnt0", gnt0, (j % 2 == 0) ? 1 : 0);
      chk("fair_gnt1", gnt1, (j % 2 == 1) ? 1 : 0);
      chk("fair_mac_a", mac_a, (j % 2 == 0) ? 1 : 3);
      tick();
      mac_done = 1; mac_out = 12'(100 + j);
      tick();
      mac_done = 0;
      chk("fair_valid", res_valid, 1);
      chk("fair_id", res_id, 12'(j % 2));
      chk("fair_data", res_data, 12'(100 + j));
      tick();
      chk("fair_idle", busy, 0);
    end
    req0 = 0; req1 = 0;
    tick();

    // Reset during WAIT after serving requester 0.
    req0 = 1; a0 = 4'd7; b0 = 4'd6;
    tick();
    chk("rst_pre_gnt0", gnt0, 1);
    req0 = 0;
    tick();
    tick();
    chk("rst_pre_wait", busy, 1);
    rst = 1;
    tick();
    rst = 0;
    chk_zero("rst_mid");
    tick();
    mac_done = 1; mac_out = 12'h077;
    tick();
    mac_done = 0; mac_out = 0;
    chk("rst_late_valid", res_valid, 0);
    chk("rst_late_busy", busy, 0);
    chk("rst_late_data", res_data, 0);
    req0 = 1; req1 = 1;
    tick();
    chk("rst_next_gnt0", gnt0, 1);
    chk("rst_next_gnt1", gnt1, 0);
    req0 = 0; req1 = 0;
    tick();
    mac_done = 1; mac_out = 12'd42;
    tick();
    mac_done = 0;
    chk("rst_next_id", res_id, 0);
    chk("rst_next_data", res_data, 42);
    tick();

`ifdef MAC_ARB_TIMEOUT_EN
    // Watchdog: no done for 8 WAIT cycles.
    req1 = 1; a1 = 4'd2; b1 = 4'd2;
    tick();
    req1 = 0;
    chk("to_gnt1", gnt1, 1);
    tick();
    for (int k = 0; k < 7; k++) tick();
    chk("to_still_wait", res_valid, 0);
    chk("to_busy", busy, 1);
    tick();
    chk("to_valid", res_valid, 1);
    chk("to_err", res_err, 1);
    chk("to_data", res_data, 0);
    chk("to_id", res_id, 1);
    tick();
    chk("to_idle", busy, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
